shreg_seq_ctrl: RTL
===================

Name: shreg_seq_ctrl

Overview:
- Sequencer for the 4-bit universal shift register (SHReg4-style: ports Pin, clk, shr, out). It takes transmit or receive commands over a valid/ready interface.
- It drives the register's shr and Pin inputs to:
  - load and serialize a word, LSB first, for TX;
  - collect WIDTH serial bits into a parallel word for RX.
- It returns a response word over a valid/ready interface.
- It sits between a command source and one shift-register instance, which it owns exclusively.

Parameters:
- WIDTH, 4, register width in bits and number of shift cycles per command; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_mode  input  1  0 = TX (parallel-in/serial-out), 1 = RX (serial-in/parallel-out).
- cmd_data  input  WIDTH  TX word; ignored for RX.
- ser_in  input  1  RX serial data, sampled on SHIFT-state edges.
- ser_out  output  1  TX serial bit, equal to sr_out[0].
- ser_strobe  output  1  high in each SHIFT cycle: TX bit valid on ser_out, or RX bit sampled from ser_in.
- rsp_valid  output  1  response word available.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  WIDTH  TX: reassembled serialized bits; RX: received word.
- busy  output  1  high in any state other than IDLE.
- sr_shr  output  1  to register shr: 0 = parallel load from Pin, 1 = shift right with Pin[WIDTH-1] entering the MSB.
- sr_pin  output  WIDTH  to register Pin.
- sr_out  input  WIDTH  from register out.

Behaviour:
- Register contract:
  - At each clk edge, shr=0 loads out <= Pin.
  - shr=1 gives out <= {Pin[WIDTH-1], out[WIDTH-1:1]}.
  - The register has no hold mode. The controller holds it by driving shr=0 with Pin=sr_out.
- Reset (rst_n=0 at an edge):
  - State returns to IDLE and the counter clears.
  - rsp_valid=0, rsp_data=0, ser_strobe=0, busy=0.
  - While rst_n=0, the controller drives sr_shr=0 and sr_pin=0, so the register clears at the same edge.
  - cmd_ready=0 while rst_n=0.
- States: IDLE, LOAD, SHIFT, DONE. The shift counter is clog2(WIDTH+1) bits wide.
- IDLE:
  - cmd_ready=1; outputs sr_shr=0, sr_pin=sr_out (hold).
  - On cmd_valid&&cmd_ready, latch cmd_mode and cmd_data and clear rsp_data.
  - Go to LOAD for TX, or to SHIFT for RX.
- LOAD (TX only, 1 cycle): sr_shr=0, sr_pin=latched word; next state SHIFT.
- SHIFT (exactly WIDTH cycles, counter 0..WIDTH-1):
  - sr_shr=1 and ser_strobe=1.
  - TX: sr_pin[WIDTH-1]=0 (zero fill). ser_out=sr_out[0] is captured into rsp_data[count].
  - RX: sr_pin[WIDTH-1]=ser_in.
  - Lower sr_pin bits are don't-care; drive them 0.
  - After the WIDTH-th shift edge, go to DONE.
- DONE:
  - rsp_valid=1; hold via sr_shr=0, sr_pin=sr_out.
  - RX: rsp_data=sr_out, so the first received bit sits at the LSB.
  - TX: rsp_data equals the original word, and the register holds 0.
  - Stay in DONE until rsp_ready=1, then go to IDLE and drop rsp_valid at that edge. rsp_data keeps its value until the next accept.
- Latency:
  - TX: accept edge T, rsp_valid first high in cycle T+2+WIDTH.
  - RX: rsp_valid first high in cycle T+1+WIDTH.
  - Minimum accept-to-accept spacing is WIDTH+3 cycles (TX) and WIDTH+2 cycles (RX), both with rsp_ready tied high.
- cmd_ready=0 outside IDLE. cmd_valid while busy is ignored and not queued. cmd_data changes after accept have no effect.
- ser_out=sr_out[0] in all states; it is meaningful only while ser_strobe=1.
- Reset mid-operation: abort immediately with no response, register cleared, cmd_ready=1 the cycle after rst_n rises.
- A command arriving on the same cycle rsp_ready completes DONE is not accepted (cmd_ready=0). It is accepted on the following IDLE cycle.

Test Plan:
- Reset then TX 4'b1011 → ser_strobe high 4 cycles with ser_out 1,1,0,1; rsp_valid 6 cycles after accept; rsp_data=1011; sr_out=0000.
- RX with ser_in 0,1,0,1 on the 4 strobe cycles → rsp_data=4'b1010, sr_out=1010; after rsp_ready, sr_out stays 1010 for 10 idle cycles.
- Backpressure: rsp_ready=0 for 5 cycles after a TX 4'b0101 → rsp_valid/rsp_data=0101 stable, cmd_ready=0, a pending cmd_valid is not accepted until one cycle after the handshake.
- rst_n=0 for one edge in the 2nd SHIFT cycle of TX 4'b1111 → sr_out=0000, rsp_valid never asserts, busy=0; the next RX 1,1,0,0 gives 4'b0011.
- Back-to-back TX 4'b0000, RX 1,0,0,0, TX 4'b1010 with cmd_valid held and rsp_ready=1 → responses 0000, 0001, 1010 at WIDTH+3 / WIDTH+2 spacing.

Source files
------------

// File: rtl/shreg_seq_ctrl.sv
// Sequencer for a WIDTH-bit universal shift register (Pin/shr/out style).
// Accepts TX (parallel-in, serial-out LSB first) and RX (serial-in,
// parallel-out) commands over valid/ready, and returns a response word
// over valid/ready. The register has no hold mode, so the controller
// reloads it with its own output whenever it must keep its contents.
module shreg_seq_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_mode,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             ser_strobe,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   output logic             sr_shr,
   output logic [WIDTH-1:0] sr_pin,
   input  logic [WIDTH-1:0] sr_out
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [CW-1:0]    cnt;
   logic             mode_q;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] rsp_q;
   logic             accept;
   logic             last_shift;

   assign cmd_ready  = rst_n && (state == IDLE);
   assign accept     = cmd_valid && cmd_ready;
   assign last_shift = (cnt == CW'(WIDTH - 1));
   assign busy       = (state != IDLE);
   assign rsp_valid  = (state == DONE);
   assign rsp_data   = rsp_q;
   assign ser_out    = sr_out[0];

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode: TX goes through LOAD, RX starts shifting at once
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = cmd_mode ? SHIFT : LOAD;
         LOAD:    state_n = SHIFT;
         SHIFT:   if (last_shift) state_n = DONE;
         DONE:    if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Command latch, shift counter and response word capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         mode_q <= 1'b0;
         word_q <= '0;
         rsp_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mode_q <= cmd_mode;
                  word_q <= cmd_data;
                  rsp_q  <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               cnt <= cnt + CW'(1);
               if (!mode_q) begin
                  for (int unsigned i = 0; i < WIDTH; i++) begin
                     if (cnt == CW'(i)) rsp_q[i] <= sr_out[0];
                  end
               end else if (last_shift) begin
                  // The register takes this same value at this edge
                  rsp_q <= {ser_in, sr_out[WIDTH-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

   // Register control: hold by self-reload, clear during reset
   always_comb begin
      sr_shr     = 1'b0;
      sr_pin     = sr_out;
      ser_strobe = 1'b0;
      if (!rst_n) begin
         sr_pin = '0;
      end else begin
         case (state)
            LOAD: sr_pin = word_q;
            SHIFT: begin
               sr_shr            = 1'b1;
               ser_strobe        = 1'b1;
               sr_pin            = '0;
               sr_pin[WIDTH-1]   = mode_q & ser_in;
            end
            default: ;
         endcase
      end
   end

endmodule
